// File: rtl/arbiter_grant_mux.sv
// rtl/arbiter_grant_mux.sv - grant-side companion to a round-robin arbiter with a 2-entry output FIFO
module arbiter_grant_mux #(
    parameter int P_REQUESTER_NUM = 3,
    parameter int P_DATA_W        = 8,
    parameter int P_ID_W          = (P_REQUESTER_NUM > 2) ? $clog2(P_REQUESTER_NUM) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [P_REQUESTER_NUM-1:0]            req_valid,
    input  logic [P_REQUESTER_NUM*P_DATA_W-1:0]   req_data,
    output logic [P_REQUESTER_NUM-1:0]            req_ready,
    output logic [P_REQUESTER_NUM-1:0]            request,
    input  logic [P_REQUESTER_NUM-1:0]            grant_valid,
    output logic                                  grant_ready,
    output logic                                  m_valid,
    output logic [P_DATA_W-1:0]                   m_data,
    output logic [P_ID_W-1:0]                     m_id,
    input  logic                                  m_ready,
    output logic                                  grant_err
);

    localparam logic [P_REQUESTER_NUM-1:0] LP_ONE = P_REQUESTER_NUM'(1);

    logic [1:0]          r_count;
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [P_DATA_W-1:0] r_data_mem [2];
    logic [P_ID_W-1:0]   r_id_mem   [2];
    logic                r_grant_err;

    logic                w_grant_ready;
    logic                w_fire;
    logic                w_onehot;
    logic                w_sel_valid;
    logic                w_good;
    logic                w_push;
    logic                w_pop;
    logic [P_ID_W-1:0]   w_idx;
    logic [P_DATA_W-1:0] w_sel_data;

    // Occupancy-only ready keeps the arbiter handshake free of combinational loops.
    assign w_grant_ready = (r_count < 2'd2) & ~rst;
    assign w_fire        = (|grant_valid) & w_grant_ready;
    assign w_onehot      = (grant_valid != '0) && ((grant_valid & (grant_valid - LP_ONE)) == '0);
    assign w_sel_valid   = |(grant_valid & req_valid);
    assign w_good        = w_fire & w_onehot & w_sel_valid;
    assign w_push        = w_good;
    assign w_pop         = (r_count != 2'd0) & m_ready;

    always_comb begin
        w_idx      = '0;
        w_sel_data = '0;
        for (int i = 0; i < P_REQUESTER_NUM; i++) begin
            if (grant_valid[i]) begin
                w_idx      = P_ID_W'(i);
                w_sel_data = req_data[i*P_DATA_W +: P_DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= 2'd0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_grant_err <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                r_data_mem[k] <= '0;
                r_id_mem[k]   <= '0;
            end
        end else begin
            if (w_push) begin
                r_data_mem[r_wr_ptr] <= w_sel_data;
                r_id_mem[r_wr_ptr]   <= w_idx;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            // A malformed grant is still consumed; only the sticky flag records it.
            if (w_fire && !w_good) begin
                r_grant_err <= 1'b1;
            end
        end
    end

    assign request     = rst ? '0 : req_valid;
    assign grant_ready = w_grant_ready;
    assign req_ready   = w_good ? grant_valid : '0;
    assign m_valid     = (r_count != 2'd0);
    assign m_data      = r_data_mem[r_rd_ptr];
    assign m_id        = r_id_mem[r_rd_ptr];
    assign grant_err   = r_grant_err;

endmodule

// File: tb/tb_arbiter_grant_mux.sv
// tb/tb_arbiter_grant_mux.sv - self-checking bench for arbiter_grant_mux against a queue reference model
`timescale 1ns/1ps
module tb_arbiter_grant_mux;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_ready;
    logic [2:0]  request;
    logic [2:0]  grant_valid;
    logic        grant_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic [1:0]  m_id;
    logic        m_ready;
    logic        grant_err;

    arbiter_grant_mux #(
        .P_REQUESTER_NUM(3),
        .P_DATA_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .request(request),
        .grant_valid(grant_valid),
        .grant_ready(grant_ready),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_id(m_id),
        .m_ready(m_ready),
        .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: FIFO contents as {id, data} in grant order, plus the sticky error bit.
    logic [9:0] q[$];
    logic       err;

    logic       wrr_on;
    int         wrr_cnt[3];
    int         wrr_n;
    int         wrr_seq[10] = '{0, 1, 2, 0, 1, 2, 0, 1, 0, 0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [2:0] v, input logic [23:0] d,
                       input logic [2:0] g, input logic mr);
        logic e_gr, e_fire, e_good;
        int   idx;
        rst = r; req_valid = v; req_data = d; grant_valid = g; m_ready = mr;
        #3;
        e_gr   = !r && (q.size() < 2);
        e_fire = (g != 3'b000) && e_gr;
        e_good = e_fire && ($countones(g) == 1) && ((g & v) != 3'b000);
        idx = 0;
        for (int i = 0; i < 3; i++) if (g[i]) idx = i;
        chk("request", 64'(request), r ? 64'd0 : 64'(v));
        chk("grant_ready", 64'(grant_ready), 64'(e_gr));
        chk("req_ready", 64'(req_ready), e_good ? 64'(g) : 64'd0);
        chk("m_valid", 64'(m_valid), 64'(q.size() != 0));
        chk("grant_err", 64'(grant_err), 64'(err));
        if (q.size() != 0) begin
            chk("m_id", 64'(m_id), 64'(q[0][9:8]));
            chk("m_data", 64'(m_data), 64'(q[0][7:0]));
        end
        if (wrr_on && m_valid && mr) begin
            wrr_cnt[m_id]++;
            wrr_n++;
            if (wrr_n == 10) begin
                chk("wrr_round_id0", 64'(wrr_cnt[0]), 64'd5);
                chk("wrr_round_id1", 64'(wrr_cnt[1]), 64'd3);
                chk("wrr_round_id2", 64'(wrr_cnt[2]), 64'd2);
                wrr_n = 0;
                for (int i = 0; i < 3; i++) wrr_cnt[i] = 0;
            end
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            err = 1'b0;
        end else begin
            if (q.size() != 0 && mr) void'(q.pop_front());
            if (e_good) q.push_back({2'(idx), d[idx*8 +: 8]});
            if (e_fire && !e_good) err = 1'b1;
        end
        #1;
    endtask

    initial begin
        logic [23:0] d;
        logic [2:0]  g;
        int          rr;

        clk = 1'b0;
        rst = 1'b1; req_valid = '0; req_data = '0; grant_valid = '0; m_ready = 1'b0;
        err = 1'b0; wrr_on = 1'b0; wrr_n = 0;
        for (int i = 0; i < 3; i++) wrr_cnt[i] = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_id", 64'(m_id), 64'd0);
        chk("rst_grant_err", 64'(grant_err), 64'd0);
        chk("rst_request", 64'(request), 64'd0);
        chk("rst_grant_ready", 64'(grant_ready), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        cyc(1'b1, 3'b111, 24'h0, 3'b000, 1'b0);

        // Single requester streaming, one cycle latency
        for (int n = 0; n < 10; n++) begin
            d = 24'($urandom);
            cyc(1'b0, 3'b001, d, 3'b001, 1'b1);
            chk("single_m_data", 64'(m_data), 64'(d[7:0]));
            chk("single_m_id", 64'(m_id), 64'd0);
        end
        cyc(1'b0, 3'b000, 24'h0, 3'b000, 1'b1);

        // Interleaved weighted grants 5/3/2
        wrr_on = 1'b1;
        for (int n = 0; n < 100; n++) begin
            cyc(1'b0, 3'b111, 24'($urandom), 3'(1 << wrr_seq[n % 10]), 1'b1);
        end
        cyc(1'b0, 3'b000, 24'h0, 3'b000, 1'b1);
        wrr_on = 1'b0;
        chk("wrr_drained", 64'(m_valid), 64'd0);

        // Backpressure
        cyc(1'b0, 3'b111, 24'($urandom), 3'b001, 1'b0);
        cyc(1'b0, 3'b111, 24'($urandom), 3'b010, 1'b0);
        chk("bp_full_grant_ready", 64'(grant_ready), 64'd0);
        chk("bp_full_req_ready", 64'(req_ready), 64'd0);
        cyc(1'b0, 3'b111, 24'($urandom), 3'b100, 1'b0);
        cyc(1'b0, 3'b111, 24'($urandom), 3'b100, 1'b1);
        chk("bp_reopen_grant_ready", 64'(grant_ready), 64'd1);
        cyc(1'b0, 3'b000, 24'h0, 3'b000, 1'b1);
        cyc(1'b0, 3'b000, 24'h0, 3'b000, 1'b1);

        // Bad grants
        cyc(1'b0, 3'b111, 24'($urandom), 3'b011, 1'b1);
        chk("bad_multi_err", 64'(grant_err), 64'd1);
        chk("bad_multi_m_valid", 64'(m_valid), 64'd0);
        chk("bad_multi_req_ready", 64'(req_ready), 64'd0);
        cyc(1'b1, 3'b000, 24'h0, 3'b000, 1'b0);
        cyc(1'b0, 3'b011, 24'($urandom), 3'b100, 1'b1);
        chk("bad_invalid_err", 64'(grant_err), 64'd1);

        // Reset with a full FIFO
        cyc(1'b0, 3'b111, 24'($urandom), 3'b001, 1'b0);
        cyc(1'b0, 3'b111, 24'($urandom), 3'b010, 1'b0);
        cyc(1'b1, 3'b111, 24'h0, 3'b000, 1'b0);
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_grant_err", 64'(grant_err), 64'd0);
        chk("midrst_request", 64'(request), 64'd0);
        d = 24'($urandom);
        cyc(1'b0, 3'b111, d, 3'b100, 1'b1);
        chk("midrst_new_valid", 64'(m_valid), 64'd1);
        chk("midrst_new_data", 64'(m_data), 64'(d[23:16]));
        chk("midrst_new_id", 64'(m_id), 64'd2);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rr = int'($urandom_range(0, 9));
            if (rr < 2)      g = 3'b000;
            else if (rr < 9) g = 3'(1 << $urandom_range(0, 2));
            else             g = 3'($urandom);
            cyc($urandom_range(0, 60) == 0, 3'($urandom), 24'($urandom), g,
                $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbiter_grant_mux.md
# arbiter_grant_mux

Grant-side companion to the interleaved weighted round-robin arbiter (`arbiter_iwrr`): it presents per-requester valid/data streams to the arbiter as a `request` vector. It consumes the arbiter's one-hot `grant_valid` through the `grant_ready` handshake. It moves the granted requester's data word into a 2-entry output FIFO that feeds one downstream valid/ready channel. It sits between N producer channels and a shared sink, with the arbiter between them deciding order.

## Interface
- `P_REQUESTER_NUM`, default 3: number of requesters, ≥ 2.
- `P_DATA_W`, default 8: data width per requester.
- `P_ID_W`, default `$clog2(P_REQUESTER_NUM)`: width of `m_id`, minimum 1.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N: requester i has a word on `req_data[i*P_DATA_W +: P_DATA_W]`.
- `req_data` in N·P_DATA_W: packed requester data.
- `req_ready` out N: one-hot pulse; word i is consumed this cycle.
- `request` out N: to the arbiter's `request` input.
- `grant_valid` in N: from the arbiter; expected one-hot or zero.
- `grant_ready` out 1: to the arbiter; the block accepts a grant this cycle.
- `m_valid` out 1: output word valid.
- `m_data` out P_DATA_W: output word.
- `m_id` out P_ID_W: index of the requester that produced `m_data`.
- `m_ready` in 1: downstream accepts the output word.
- `grant_err` out 1: sticky flag for a malformed grant.

## Operation
- `request = req_valid` while `rst` = 0; `request` is forced to 0 while `rst` = 1.
- `grant_ready = (count < 2) & ~rst`.
  - `count` is the output FIFO occupancy, 0..2, and is registered.
  - `grant_ready` therefore has no combinational path from `grant_valid` or `m_ready`.
- Grant fire: `|grant_valid & grant_ready`. On a fire:
  - Good grant: `grant_valid` is one-hot and `req_valid[i]` = 1 for the granted i.
    - `req_ready[i]` = 1 in the same cycle.
    - {i, `req_data[i]`} is pushed into the FIFO.
  - Bad grant: more than one bit set, or the granted requester has `req_valid` = 0.
    - `grant_err` is set (sticky until `rst`).
    - Nothing is pushed and `req_ready` stays 0.
    - The grant is still consumed, so `grant_ready` is asserted as normal.
- `req_ready` is 0 in every cycle without a good grant fire.
- Output FIFO: 2 entries, `wr_ptr`/`rd_ptr` 1 bit each, wrapping.
  - Pop when `m_valid & m_ready`.
  - `m_valid = (count != 0)`.
  - `m_data`/`m_id` come from the head entry.
  - Push and pop in the same cycle leave `count` unchanged.
- There is no reordering: the output order is exactly the order of good grant fires.
- Reset values:
  - `count` = 0, both pointers 0.
  - `m_valid` = 0, `m_data` = 0, `m_id` = 0, `grant_err` = 0.
  - `req_ready` = 0, `request` = 0, `grant_ready` = 0.
- Reset mid-operation clears the FIFO. Buffered words are dropped and not replayed. The first grant can be accepted in the first cycle after `rst` deasserts.

## Timing
- Latency: a word accepted on a good grant fire in cycle T appears on `m_valid`/`m_data` in cycle T+1 when the FIFO was empty.
- Throughput: 1 word per cycle sustained while `m_ready` = 1. With `count` = 1, a push and a pop in the same cycle are both allowed.
- Full (`count` = 2): `grant_ready` = 0. The arbiter is expected to hold its grant, and no `req_ready` is issued.
- `grant_ready` rises in the cycle after the pop that makes `count` = 1.
- Empty: `m_valid` = 0, and `m_data`/`m_id` hold their last value (don't care).
- `grant_err` rises in the cycle after the offending fire.

## Test plan
- Single requester, `req_valid` = 3'b001, arbiter `grant_valid` = 3'b001 every cycle, `m_ready` = 1:
  - `req_ready[0]` pulses every cycle.
  - `m_id` = 0, and `m_data` tracks `req_data[0]` delayed by 1 cycle.
- All requesters valid, `arbiter_iwrr` with weights {5,3,2}, `m_ready` = 1, 100 cycles:
  - The `m_id` counts per 10-grant round are 5/3/2.
  - Words per requester arrive in order and none are lost.
- Backpressure, `m_ready` = 0:
  - After 2 grant fires, `count` = 2 and `grant_ready` = 0, with no further `req_ready`.
  - Raising `m_ready` for 1 cycle gives `grant_ready` = 1 on the next cycle.
  - Output order matches the grant order.
- Bad grants:
  - `grant_valid` = 3'b011 gives `grant_err` = 1 next cycle, `count` unchanged, `req_ready` = 0.
  - `grant_valid` = 3'b100 with `req_valid[2]` = 0 also sets `grant_err`.
- Reset mid-stream with `count` = 2:
  - `rst` = 1 for 1 cycle gives `m_valid` = 0, `grant_err` = 0, `request` = 0.
  - The next fire after release produces `m_valid` at T+1 with the new data.
